// File: rtl/mem_burst_reader_pkg.sv
// Shared types and default geometry for the capture-memory read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_burst_reader_pkg;

   localparam int DEF_ROW       = 19;
   localparam int DEF_WIDTH     = 128;
   localparam int DEF_LOG_WIDTH = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mem_burst_fifo2.sv
// Two-entry row FIFO between the memory return path and the consumer stream.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: caller never pushes when full unless it also pops that cycle.
module mem_burst_fifo2
   import mem_burst_reader_pkg::*;
#(
   parameter int W = DEF_ROW
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [1:0]   cnt,
   output logic [W-1:0] head_dat
);

   logic [W-1:0] ent [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Qualify push/pop against occupancy; full+push is only legal alongside a pop.
   always_comb begin
      pop_ok  = pop && (cnt != 2'd0);
      push_ok = push && ((cnt != 2'd2) || pop_ok);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent[0] <= '0;
         ent[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push_ok) begin
            ent[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_dat = ent[rd_ptr];

endmodule

// File: rtl/mem_burst_reader.sv
// Reads len rows from the capture memory onto a valid/ready stream; optional MEM_BURST_READER_STATS_EN adds a restart counter.
// Latency: first row reaches out_data two clocks after mem_we first rises; then one row per clock.
// Backpressure: when the FIFO would overflow, mem_we drops and the burst restarts from row 0, discarding rows already delivered.
module mem_burst_reader
   import mem_burst_reader_pkg::*;
#(
   parameter int ROW       = DEF_ROW,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int LOG_WIDTH = DEF_LOG_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LOG_WIDTH:0]   len,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_en,
   output logic                 mem_we,
   input  logic [ROW-1:0]       mem_data,
   output logic [ROW-1:0]       out_data,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef MEM_BURST_READER_STATS_EN
   ,
   output logic [LOG_WIDTH:0]   restarts
`endif
);

   state_t             state;
   state_t             state_nxt;
   logic [LOG_WIDTH:0] len_q;
   logic [LOG_WIDTH:0] iss;
   logic [LOG_WIDTH:0] iss_nxt;
   logic [LOG_WIDTH:0] acc;
   logic [LOG_WIDTH:0] tag;
   logic               inflight;
   logic               issue;
   logic               start_ok;
   logic               push;
   logic               pop;
   logic [1:0]         cnt;
   logic [1:0]         cnt_next;
   logic [2:0]         occ;

   // Return-path and FIFO bookkeeping that feeds the issue decision.
   always_comb begin
      start_ok = (state == IDLE) && start && (len != '0);
      pop      = out_valid && out_ready;
      push     = inflight && (tag == acc);
      cnt_next = cnt - {1'b0, pop};
      occ      = {1'b0, cnt_next} + {2'b00, inflight};
   end

   // Next-state, issue and done decode.
   always_comb begin
      state_nxt = state;
      iss_nxt   = iss;
      issue     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = READ;
               iss_nxt   = '0;
            end
         end
         READ: begin
            if (iss == len_q) begin
               state_nxt = DRAIN;
            end else if ((iss < acc) || (occ < 3'd2)) begin
               issue   = 1'b1;
               iss_nxt = iss + 1'b1;
            end else begin
               state_nxt = HOLD;
               iss_nxt   = '0;
            end
         end
         HOLD: begin
            if (!inflight && (cnt_next == 2'd0)) begin
               state_nxt = READ;
               iss_nxt   = '0;
            end
         end
         DRAIN: begin
            if ((acc == len_q) && (cnt == 2'd0) && !inflight) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and the one-deep in-flight read tracker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         iss      <= '0;
         acc      <= '0;
         tag      <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         iss      <= iss_nxt;
         inflight <= issue;
         tag      <= iss;
         if (start_ok) begin
            len_q <= len;
            acc   <= '0;
         end else if (push) begin
            acc <= acc + 1'b1;
         end
      end
   end

   mem_burst_fifo2 #(.W(ROW)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (mem_data),
      .pop      (pop),
      .cnt      (cnt),
      .head_dat (out_data)
   );

   assign busy      = (state != IDLE);
   assign mem_en    = 1'b0;
   assign mem_we    = issue;
   assign out_valid = (cnt != 2'd0);

`ifdef MEM_BURST_READER_STATS_EN
   logic enter_hold;
   assign enter_hold = (state == READ) && (state_nxt == HOLD);

   // Count READ->HOLD restarts for the current burst, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         restarts <= '0;
      end else if (start_ok) begin
         restarts <= '0;
      end else if (enter_hold && (restarts != '1)) begin
         restarts <= restarts + 1'b1;
      end
   end
`endif

   // A returning row can only be one already accepted or the next one due.
   a_tag_order: assert property (@(posedge clk) disable iff (rst) inflight |-> (tag <= acc));
   a_len_range: assert property (@(posedge clk) disable iff (rst)
                                 start_ok |-> (len <= (LOG_WIDTH+1)'(WIDTH)));

endmodule
